// File: rtl/crypt_ctrl_fsm_if.sv
// Handshake bundle between crypt_ctrl_fsm and the Rx/Tx FIFOs and cipher core.
// master = control unit, slave = FIFO/core side.
interface crypt_ctrl_fsm_if;
    logic emptyRx;
    logic fullRx;
    logic emptyTx;
    logic fullTx;
    logic data_done;
    logic accepted;
    logic read_fifo;
    logic rcv_deq;
    logic trans_enq;

    modport master (
        input  emptyRx, fullRx, emptyTx, fullTx, data_done, accepted,
        output read_fifo, rcv_deq, trans_enq
    );

    modport slave (
        output emptyRx, fullRx, emptyTx, fullTx, data_done, accepted,
        input  read_fifo, rcv_deq, trans_enq
    );
endinterface

// File: rtl/crypt_ctrl_fsm.sv
// Main control FSM for the encrypt/decrypt datapath: key load, data retry, Tx enqueue, status word.
// Optional macro CRYPT_CTRL_KEY_GATE_EN: hold data reads in IDLE until a key has been loaded.
module crypt_ctrl_fsm #(
    parameter int KEY_WORDS        = 4,
    parameter int KEY_SETUP_CYCLES = 3,
    parameter int MAX_RETRY        = 3
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       key_in,
    input  logic                       is_encryption_pulse,
    input  logic                       is_decryption_pulse,
    crypt_ctrl_fsm_if.master           bus,
    output logic                       is_encrypt,
    output logic [$clog2(KEY_WORDS):0] key_word_idx,
    output logic [4:0]                 status_bits
);

    localparam int KIDX_W = $clog2(KEY_WORDS) + 1;
    localparam int SET_W  = $clog2(KEY_SETUP_CYCLES + 1);
    localparam int RTY_W  = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        KEY_RD   = 3'd1,
        KEY_WAIT = 3'd2,
        DATA_RD  = 3'd3,
        CHK      = 3'd4,
        ENQ      = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [KIDX_W-1:0]  key_word_idx_q, key_word_idx_d;
    logic [SET_W-1:0]   setup_cnt_q, setup_cnt_d;
    logic [RTY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic               key_valid_q, key_valid_d;
    logic               err_q, err_d;
    logic [4:0]         status_q, status_d;

    logic               mode_s;
    logic               data_ok_s;
    logic [RTY_W-1:0]   retry_inc_s;
    logic               read_fifo_s;
    logic               rcv_deq_s;
    logic               trans_enq_s;

`ifdef CRYPT_CTRL_KEY_GATE_EN
    assign data_ok_s = ~bus.emptyRx & key_valid_q;
`else
    assign data_ok_s = ~bus.emptyRx;
`endif

    assign retry_inc_s = retry_cnt_q + RTY_W'(1);

    // Mode register lives in status bit 2; encrypt wins when both pulses coincide.
    always_comb begin
        mode_s = status_q[2];
        if (is_encryption_pulse) begin
            mode_s = 1'b1;
        end else if (is_decryption_pulse) begin
            mode_s = 1'b0;
        end else begin
            mode_s = status_q[2];
        end
        status_d = {err_q, key_valid_q, mode_s, ~bus.emptyTx, bus.fullRx};
    end

    // Next-state, counter and strobe logic.
    always_comb begin
        state_d        = state_q;
        key_word_idx_d = key_word_idx_q;
        setup_cnt_d    = setup_cnt_q;
        retry_cnt_d    = retry_cnt_q;
        key_valid_d    = key_valid_q;
        err_d          = err_q;
        read_fifo_s    = 1'b0;
        rcv_deq_s      = 1'b0;
        trans_enq_s    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.data_done) begin
                    state_d = ENQ;
                end else if (key_in) begin
                    state_d        = KEY_RD;
                    key_valid_d    = 1'b0;
                    err_d          = 1'b0;
                    key_word_idx_d = '0;
                    retry_cnt_d    = '0;
                end else if (data_ok_s) begin
                    state_d = DATA_RD;
                end else begin
                    state_d = IDLE;
                end
            end

            KEY_RD: begin
                if (!bus.emptyRx) begin
                    rcv_deq_s      = 1'b1;
                    key_word_idx_d = key_word_idx_q + KIDX_W'(1);
                    if (key_word_idx_q == KIDX_W'(KEY_WORDS - 1)) begin
                        state_d     = KEY_WAIT;
                        setup_cnt_d = '0;
                    end else begin
                        state_d = KEY_RD;
                    end
                end else begin
                    state_d = KEY_RD;
                end
            end

            KEY_WAIT: begin
                if (setup_cnt_q == SET_W'(KEY_SETUP_CYCLES - 1)) begin
                    setup_cnt_d = '0;
                    key_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    setup_cnt_d = setup_cnt_q + SET_W'(1);
                    state_d     = KEY_WAIT;
                end
            end

            DATA_RD: begin
                read_fifo_s = 1'b1;
                state_d     = CHK;
            end

            // A word rejected MAX_RETRY times is popped anyway so the FIFO cannot wedge.
            CHK: begin
                if (bus.accepted) begin
                    rcv_deq_s   = 1'b1;
                    retry_cnt_d = '0;
                    state_d     = IDLE;
                end else if (retry_inc_s == RTY_W'(MAX_RETRY)) begin
                    rcv_deq_s   = 1'b1;
                    err_d       = 1'b1;
                    retry_cnt_d = '0;
                    state_d     = IDLE;
                end else begin
                    retry_cnt_d = retry_inc_s;
                    state_d     = DATA_RD;
                end
            end

            ENQ: begin
                if (!bus.fullTx) begin
                    trans_enq_s = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = ENQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q        <= IDLE;
            key_word_idx_q <= '0;
            setup_cnt_q    <= '0;
            retry_cnt_q    <= '0;
            key_valid_q    <= 1'b0;
            err_q          <= 1'b0;
            status_q       <= 5'b00100;
        end else begin
            state_q        <= state_d;
            key_word_idx_q <= key_word_idx_d;
            setup_cnt_q    <= setup_cnt_d;
            retry_cnt_q    <= retry_cnt_d;
            key_valid_q    <= key_valid_d;
            err_q          <= err_d;
            status_q       <= status_d;
        end
    end

    assign bus.read_fifo = read_fifo_s;
    assign bus.rcv_deq   = rcv_deq_s;
    assign bus.trans_enq = trans_enq_s;
    assign key_word_idx  = key_word_idx_q;
    assign status_bits   = status_q;
    assign is_encrypt    = status_q[2];

endmodule

// File: doc/crypt_ctrl_fsm.md
# crypt_ctrl_fsm

Parametrised main control unit for the encrypt/decrypt datapath. It loads a multi-word key from the receive FIFO and sequences data words from the receive FIFO into the cipher core, retrying rejected words a bounded number of times. It enqueues finished blocks into the transmit FIFO under back-pressure and publishes a registered status word to the host interface. It sits between the Rx/Tx FIFOs, the key generator and the cipher core.

## Interface
- KEY_WORDS, 4: Rx words dequeued per key load (≥1).
- KEY_SETUP_CYCLES, 3: key-generator settle cycles after the last key word (≥1).
- MAX_RETRY, 3: rejected reads of one word before it is dropped (≥1).
- clk  in  1  clock, rising edge.
- n_reset  in  1  reset, asynchronous, active-low.
- key_in  in  1  host request to load a new key.
- is_encryption_pulse  in  1  one-cycle request for encrypt mode.
- is_decryption_pulse  in  1  one-cycle request for decrypt mode.
- emptyRx, fullRx  in  1 each  Rx FIFO flags.
- emptyTx, fullTx  in  1 each  Tx FIFO flags.
- data_done  in  1  cipher core has a finished block.
- accepted  in  1  core accepted the word read this attempt (sampled in CHK).
- is_encrypt  out  1  current mode; equals status_bits[2].
- read_fifo  out  1  present Rx head word to the core.
- rcv_deq  out  1  pop Rx FIFO.
- trans_enq  out  1  push Tx FIFO.
- key_word_idx  out  $clog2(KEY_WORDS)+1  index of the key word currently being dequeued.
- status_bits  out  5  {err, key_valid, mode, !emptyTx, fullRx}, registered.

## Operation
- States: IDLE, KEY_RD, KEY_WAIT, DATA_RD, CHK, ENQ.
- IDLE priority: data_done → ENQ; else key_in → KEY_RD; else !emptyRx (and key gate, see Configuration) → DATA_RD.
- Entering KEY_RD clears key_valid, err, key_word_idx and retry count.
- KEY_RD: when !emptyRx, rcv_deq=1 and key_word_idx increments. When emptyRx, it stalls with rcv_deq=0. After word KEY_WORDS-1 is popped → KEY_WAIT.
- KEY_WAIT: counts KEY_SETUP_CYCLES cycles, then sets key_valid and → IDLE.
- DATA_RD: read_fifo=1 for one cycle → CHK.
- CHK:
  - accepted=1: rcv_deq=1, retry count cleared, → IDLE.
  - Otherwise retry count increments. When it reaches MAX_RETRY: err set (sticky), rcv_deq=1 drops the word, count cleared, → IDLE. Below MAX_RETRY: → DATA_RD.
- ENQ: trans_enq=1 only when !fullTx, then → IDLE. It holds in ENQ while fullTx.
- Mode: an encryption pulse sets mode=1 and a decryption pulse sets mode=0. If both pulse in the same cycle, encrypt wins. Mode is independent of state.
- rcv_deq, read_fifo and trans_enq are Moore/combinational from state plus the FIFO flag/accepted, never registered.

## Timing
- Reset values:
  - state IDLE, key_valid 0, err 0, all counters 0.
  - status_bits = 5'b00100 (encrypt mode), is_encrypt 1.
  - read_fifo, rcv_deq, trans_enq all 0.
- status_bits[1:0] are registered copies of !emptyTx and fullRx, with 1-cycle lag.
- status_bits[2] updates on the edge after a mode pulse.
- status_bits[3] rises one cycle after internal key_valid is set.
- Key load, no stalls: 1 (IDLE) + KEY_WORDS + KEY_SETUP_CYCLES cycles from key_in to key_valid.
- Data word accepted first try: IDLE→DATA_RD→CHK→IDLE, 3 cycles, with rcv_deq on the CHK cycle.
- Asserting n_reset mid-operation returns to IDLE within the same cycle (asynchronous). A partial key is discarded.
- key_in outside IDLE is ignored, with no queuing. Mode pulses are accepted in any state.

## Configuration
- CRYPT_CTRL_KEY_GATE_EN defined: IDLE leaves for DATA_RD only when key_valid=1, so data waits in the Rx FIFO until a key is loaded.
- Undefined: data reads proceed regardless of key_valid, with the same priority order.

## Test plan
- Reset then idle: status_bits=5'b00100, is_encrypt=1, and no strobes for 10 cycles.
- key_in with 4 words queued (defaults): rcv_deq high 4 consecutive cycles with key_word_idx 0..3, key_valid after 3 more cycles, and status_bits[3]=1 one cycle later.
- emptyRx asserted after key word 2: FSM stalls in KEY_RD with rcv_deq=0, and resumes at idx 2 when emptyRx drops.
- accepted held 0 for a data word, MAX_RETRY=3: three read_fifo pulses, then rcv_deq once and status_bits[4]=1. A following key_in clears it.
- data_done with fullTx=1 for 5 cycles: trans_enq stays 0, then asserts for exactly 1 cycle after fullTx falls.
- Both mode pulses asserted in the same cycle → is_encrypt=1. With the macro defined and key_valid=0 and emptyRx=0, read_fifo never asserts.
